// File: rtl/tag_retire_queue.sv
// In-order retire queue: records allocated tags in program order, marks them done on
// completion and hands the oldest consecutive done tags back to the freelist.
module tag_retire_queue #(
  parameter  int DEPTH  = 16,
  parameter  int TAGS   = 16,
  parameter  int ALLOC  = 4,
  parameter  int COMP   = 4,
  parameter  int RETIRE = 4,
  localparam int TAG_W  = $clog2(TAGS)
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          flush_,
  input  logic [ALLOC-1:0]              alloc_,
  input  logic [ALLOC-1:0][TAG_W-1:0]   alloc_tag,
  input  logic [COMP-1:0]               comp_,
  input  logic [COMP-1:0][TAG_W-1:0]    comp_tag,
  output logic [RETIRE-1:0]             ret_we_,
  output logic [RETIRE-1:0][TAG_W-1:0]  ret_wd,
  output logic                          busy,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             done_q, done_d;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [PW-1:0]                head_q, head_d;
  logic [PW-1:0]                tail_q, tail_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         busy_q, busy_d;
  logic                         empty_q, empty_d;
  logic                         overflow_q, overflow_d;
  logic [RETIRE-1:0]            ret_we_q, ret_we_d;
  logic [RETIRE-1:0][TAG_W-1:0] ret_wd_q, ret_wd_d;

  logic [CW-1:0] n_ret, n_alloc, free_cnt;
  logic [PW-1:0] idx, off;
  logic          stop, accept;

  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    tag_d      = tag_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    ret_we_d   = '1;
    ret_wd_d   = ret_wd_q;
    n_ret      = '0;
    n_alloc    = '0;
    idx        = '0;
    off        = '0;
    stop       = 1'b0;

    // Retire decision looks only at start-of-cycle valid/done.
    for (int i = 0; i < RETIRE; i++) begin
      idx = head_q + PW'(i);
      if (!stop && valid_q[idx] && done_q[idx]) begin
        ret_we_d[i] = 1'b0;
        ret_wd_d[i] = tag_q[idx];
        n_ret       = n_ret + CW'(1);
      end else begin
        stop = 1'b1;
      end
    end

    for (int j = 0; j < DEPTH; j++) begin
      for (int c = 0; c < COMP; c++) begin
        if (!comp_[c] && valid_q[j] && (tag_q[j] == comp_tag[c])) done_d[j] = 1'b1;
      end
    end

    for (int i = 0; i < RETIRE; i++) begin
      if (!ret_we_d[i]) begin
        idx         = head_q + PW'(i);
        valid_d[idx] = 1'b0;
        done_d[idx]  = 1'b0;
      end
    end
    head_d = head_q + n_ret[PW-1:0];

    for (int a = 0; a < ALLOC; a++) begin
      if (!alloc_[a]) n_alloc = n_alloc + CW'(1);
    end
    free_cnt = CW'(DEPTH) - count_q;
    accept   = (n_alloc <= free_cnt);
    if (!accept) overflow_d = 1'b1;

    // Allocated slots were free at start of cycle, so they never collide with retiring ones.
    if (accept) begin
      for (int a = 0; a < ALLOC; a++) begin
        if (!alloc_[a]) begin
          idx          = tail_q + off;
          valid_d[idx] = 1'b1;
          done_d[idx]  = 1'b0;
          tag_d[idx]   = alloc_tag[a];
          off          = off + PW'(1);
        end
      end
    end
    tail_d = tail_q + off;

    count_d = count_q + (accept ? n_alloc : '0) - n_ret;
    busy_d  = (CW'(DEPTH) - count_d) < CW'(ALLOC);
    empty_d = (count_d == '0);

    if (!flush_) begin
      valid_d    = '0;
      done_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      busy_d     = 1'b0;
      empty_d    = 1'b1;
      overflow_d = 1'b0;
      ret_we_d   = '1;
      ret_wd_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      valid_q    <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      ret_we_q   <= '1;
      ret_wd_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      ret_we_q   <= ret_we_d;
      ret_wd_q   <= ret_wd_d;
    end
  end

  // Tag payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign ret_we_  = ret_we_q;
  assign ret_wd   = ret_wd_q;
  assign busy     = busy_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tag_retire_queue.sv
// Scoreboard bench for tag_retire_queue: allocated tags are queued in program order and
// every retire pulse must pop them in that order; directed checks cover timing corners.
module tb_tag_retire_queue;

  localparam int DEPTH  = 16;
  localparam int ALLOC  = 4;
  localparam int COMP   = 4;
  localparam int RETIRE = 4;
  localparam int TAG_W  = 4;

  logic                          clk = 1'b0;
  logic                          reset_ = 1'b0;
  logic                          flush_ = 1'b1;
  logic [ALLOC-1:0]              alloc_ = '1;
  logic [ALLOC-1:0][TAG_W-1:0]   alloc_tag = '0;
  logic [COMP-1:0]               comp_ = '1;
  logic [COMP-1:0][TAG_W-1:0]    comp_tag = '0;
  logic [RETIRE-1:0]             ret_we_;
  logic [RETIRE-1:0][TAG_W-1:0]  ret_wd;
  logic                          busy;
  logic                          empty;
  logic [4:0]                    count;
  logic                          overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [TAG_W-1:0] sb[$];
  bit m_ovf = 1'b0;

  tag_retire_queue dut (
    .clk(clk), .reset_(reset_), .flush_(flush_),
    .alloc_(alloc_), .alloc_tag(alloc_tag),
    .comp_(comp_), .comp_tag(comp_tag),
    .ret_we_(ret_we_), .ret_wd(ret_wd),
    .busy(busy), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  // Apply current inputs at the next edge, then score retire output and occupancy.
  task automatic step();
    int n;
    int k;
    bit fl;
    logic [RETIRE-1:0] shp;
    logic [TAG_W-1:0] exp_tag;
    n  = 0;
    fl = !flush_;
    for (int a = 0; a < ALLOC; a++) if (!alloc_[a]) n++;
    if (!fl) begin
      if (n > DEPTH - sb.size()) m_ovf = 1'b1;
      else for (int a = 0; a < ALLOC; a++) if (!alloc_[a]) sb.push_back(alloc_tag[a]);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      m_ovf = 1'b0;
    end
    k = 0;
    while (k < RETIRE && !ret_we_[k]) k++;
    shp = '1;
    shp = shp << k;
    chk("ret_shape", ret_we_, shp);
    if (k > sb.size()) chk("sb_underrun", k, sb.size());
    else for (int i = 0; i < k; i++) begin
      exp_tag = sb.pop_front();
      chk("ret_tag", ret_wd[i], exp_tag);
    end
    chk("count", count, sb.size());
    chk("empty", empty, (sb.size() == 0));
    chk("busy", busy, ((DEPTH - sb.size()) < ALLOC));
    chk("overflow", overflow, m_ovf);
    alloc_ = '1;
    comp_  = '1;
    flush_ = 1'b1;
  endtask

  initial begin
    logic [RETIRE-1:0] pat [5];
    pat = '{4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1111};

    // Reset / idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", ret_we_, 4'b1111);
    chk("rst_wd", ret_wd, 16'h0000);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    reset_ = 1'b1;
    step();

    // In-order flow
    alloc_ = 4'b0000; alloc_tag = {4'd9, 4'd1, 4'd7, 4'd3};
    step();
    comp_ = 4'b0000; comp_tag = {4'd9, 4'd1, 4'd7, 4'd3};
    step();
    chk("inord_early", ret_we_, 4'b1111);
    step();
    chk("inord_we", ret_we_, 4'b0000);
    chk("inord_wd", ret_wd, 16'h9173);
    chk("inord_count", count, 0);
    chk("inord_empty", empty, 1);

    // Out-of-order completion
    alloc_ = 4'b1000; alloc_tag = {4'd0, 4'd8, 4'd5, 4'd2};
    step();
    comp_ = 4'b1110; comp_tag = {4'd0, 4'd0, 4'd0, 4'd8};
    step();
    chk("ooo_hold1", ret_we_, 4'b1111);
    comp_ = 4'b1110; comp_tag = {4'd0, 4'd0, 4'd0, 4'd5};
    step();
    chk("ooo_hold2", ret_we_, 4'b1111);
    step();
    chk("ooo_hold3", ret_we_, 4'b1111);
    comp_ = 4'b1110; comp_tag = {4'd0, 4'd0, 4'd0, 4'd2};
    step();
    chk("ooo_hold4", ret_we_, 4'b1111);
    step();
    chk("ooo_we", ret_we_, 4'b1000);
    chk("ooo_wd0", ret_wd[0], 2);
    chk("ooo_wd1", ret_wd[1], 5);
    chk("ooo_wd2", ret_wd[2], 8);
    chk("ooo_wd3_hold", ret_wd[3], 9);
    step();
    chk("ooo_idle", ret_we_, 4'b1111);

    // Fill to 14, overflow, then retire capped at 4 per cycle across the wrap
    alloc_ = 4'b0000; alloc_tag = {4'd3, 4'd2, 4'd1, 4'd0};   step();
    alloc_ = 4'b0000; alloc_tag = {4'd7, 4'd6, 4'd5, 4'd4};   step();
    alloc_ = 4'b0000; alloc_tag = {4'd11, 4'd10, 4'd9, 4'd8}; step();
    alloc_ = 4'b1100; alloc_tag = {4'd0, 4'd0, 4'd13, 4'd12}; step();
    chk("fill_count", count, 14);
    chk("fill_busy", busy, 1);
    alloc_ = 4'b0000; alloc_tag = {4'd1, 4'd0, 4'd15, 4'd14};
    step();
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 14);
    comp_ = 4'b0000; comp_tag = {4'd7, 4'd6, 4'd5, 4'd4};     step();
    chk("cap_hold1", ret_we_, 4'b1111);
    comp_ = 4'b0000; comp_tag = {4'd11, 4'd10, 4'd9, 4'd8};   step();
    chk("cap_hold2", ret_we_, 4'b1111);
    comp_ = 4'b1100; comp_tag = {4'd0, 4'd0, 4'd13, 4'd12};   step();
    chk("cap_hold3", ret_we_, 4'b1111);
    comp_ = 4'b0000; comp_tag = {4'd3, 4'd2, 4'd1, 4'd0};     step();
    chk("cap_hold4", ret_we_, 4'b1111);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("cap_we", ret_we_, pat[c]);
    end
    chk("cap_count", count, 0);

    // Sparse lanes, no-match completion, same-cycle alloc+comp
    alloc_ = 4'b1010; alloc_tag = {4'd0, 4'd11, 4'd0, 4'd10};
    comp_  = 4'b1110; comp_tag  = {4'd0, 4'd0, 4'd0, 4'd12};
    step();
    chk("sparse_count", count, 2);
    chk("sparse_we", ret_we_, 4'b1111);
    step();
    step();
    chk("nomatch_we", ret_we_, 4'b1111);
    alloc_ = 4'b1110; alloc_tag = {4'd0, 4'd0, 4'd0, 4'd5};
    comp_  = 4'b1110; comp_tag  = {4'd0, 4'd0, 4'd0, 4'd5};
    step();
    comp_ = 4'b1100; comp_tag = {4'd0, 4'd0, 4'd11, 4'd10};
    step();
    chk("same_hold", ret_we_, 4'b1111);
    step();
    chk("same_we", ret_we_, 4'b1100);
    step();
    chk("same_idle", ret_we_, 4'b1111);
    comp_ = 4'b1110; comp_tag = {4'd0, 4'd0, 4'd0, 4'd5};
    step();
    step();
    chk("same_late_we", ret_we_, 4'b1110);
    chk("same_late_wd", ret_wd[0], 5);

    // Flush mid-flight with three non-head entries done
    alloc_ = 4'b0000; alloc_tag = {4'd3, 4'd2, 4'd1, 4'd0}; step();
    alloc_ = 4'b1100; alloc_tag = {4'd0, 4'd0, 4'd5, 4'd4}; step();
    comp_ = 4'b0001; comp_tag = {4'd3, 4'd2, 4'd1, 4'd0};
    step();
    chk("fl_pre_we", ret_we_, 4'b1111);
    chk("fl_pre_count", count, 6);
    flush_ = 1'b0;
    alloc_ = 4'b1110; alloc_tag = {4'd0, 4'd0, 4'd0, 4'd7};
    comp_  = 4'b1110; comp_tag  = {4'd0, 4'd0, 4'd0, 4'd0};
    step();
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_we", ret_we_, 4'b1111);
    chk("fl_wd", ret_wd, 16'h0000);
    chk("fl_ovf", overflow, 0);
    step();
    step();
    chk("fl_post_we", ret_we_, 4'b1111);
    alloc_ = 4'b1110; alloc_tag = {4'd0, 4'd0, 4'd0, 4'd6}; step();
    comp_  = 4'b1110; comp_tag  = {4'd0, 4'd0, 4'd0, 4'd6}; step();
    step();
    chk("fl_after_we", ret_we_, 4'b1110);
    chk("fl_after_wd", ret_wd[0], 6);

    // Asynchronous reset just before a retire edge
    alloc_ = 4'b1100; alloc_tag = {4'd0, 4'd0, 4'd2, 4'd1}; step();
    comp_  = 4'b1100; comp_tag  = {4'd0, 4'd0, 4'd2, 4'd1}; step();
    #2 reset_ = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_we", ret_we_, 4'b1111);
    @(posedge clk);
    #1;
    chk("arst_edge_we", ret_we_, 4'b1111);
    reset_ = 1'b1;
    sb.delete();
    m_ovf = 1'b0;
    step();
    chk("arst_post_we", ret_we_, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
